rng_dice: RTL
=============

# rng_dice

Downstream consumer of the 4-bit LFSR random source. On a roll request it samples the 4-bit stream and rejection-samples it into an unbiased die face 1..6. The result is presented on a valid/ack handshake. The block also keeps a saturating count of rejected samples for bench statistics.

## Interface
- MAX_TRIES, default 8: consecutive rejected samples allowed per roll before the roll aborts with an error; legal range 1..255.
- clk  in  1  rising-edge clock, shared with the RNG stage.
- rst  in  1  synchronous, active-high reset.
- rnd  in  4  random sample from the upstream LFSR; a new value every cycle; used only in DRAW.
- roll  in  1  roll request; sampled only in IDLE; ignored in every other state.
- die  out  3  result face 1..6, or 0 on abort; reset value 0; holds its last value after ack.
- die_valid  out  1  result available; high for the whole of HOLD; reset value 0.
- die_ack  in  1  consumer accepts the result; meaningful only while die_valid=1.
- err  out  1  qualifies die_valid: the roll aborted after MAX_TRIES rejects; reset value 0.
- busy  out  1  high in DRAW and HOLD; reset value 0.
- rej_cnt  out  8  total rejected samples since reset; saturates at 255; reset value 0.

## Operation
- FSM states: IDLE, DRAW, HOLD. Reset state is IDLE.
- Rejection counter `tries`: width clog2(MAX_TRIES+1) bits; cleared on entry to DRAW.
- IDLE:
  - busy=0, die_valid=0.
  - roll=1 → DRAW; tries←0.
- DRAW, evaluated every cycle on the current rnd:
  - rnd≤11 (accept):
    - die←rnd+1 if rnd≤5, else die←rnd−5.
    - err←0, die_valid←1, → HOLD.
  - rnd≥12 (reject):
    - rej_cnt←rej_cnt+1, saturating at 255.
    - If tries+1==MAX_TRIES: die←0, err←1, die_valid←1, → HOLD.
    - Otherwise: tries←tries+1, stay in DRAW.
- HOLD:
  - die, err and die_valid are stable.
  - die_ack=1 → IDLE; die_valid←0, err←0. die keeps its value.
  - roll is ignored.
- die_ack is ignored when die_valid=0.
- No roll is queued: a roll pulse seen outside IDLE is lost.
- Mapping 0..11 → 1..6 uses each face exactly twice. For a uniform 4-bit source the output is unbiased.

## Timing
- roll high at edge t → DRAW from t+1. The rnd value present in cycle t+1 is examined.
- Best-case latency: die_valid rises at edge t+2, i.e. 2 cycles after roll is sampled.
- Each reject adds exactly one cycle.
- Worst case: abort, with die_valid rising at t+1+MAX_TRIES.
- die_ack sampled at edge a → die_valid low and state IDLE after a. The earliest next roll is accepted at edge a+1.
- die_ack high in the same cycle that die_valid first rises has no effect; the ack must be seen while in HOLD.
- rej_cnt updates in the cycle after the rejected sample. At 255 it holds, with no wrap.
- rst=1 at any edge, including mid-DRAW or in HOLD:
  - State→IDLE.
  - All outputs take their reset values: die=0, die_valid=0, err=0, busy=0, rej_cnt=0.
  - The in-flight roll is discarded; rst has priority over every other input.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Accept path:
  - Stimulus: rst 2 cycles; roll pulse; rnd=7 in the DRAW cycle.
  - Required: die=2, die_valid=1, err=0 two cycles after roll, held until die_ack; rej_cnt=0.
- Mapping sweep:
  - Stimulus: one roll per rnd value 0..11, forced on the first DRAW cycle.
  - Required: die = 1,2,3,4,5,6,1,2,3,4,5,6.
- Reject then accept:
  - Stimulus: rnd=13, 15, 12, then 4.
  - Required: die_valid rises 5 cycles after roll; die=5; rej_cnt=3; busy high throughout.
- Abort:
  - Stimulus: MAX_TRIES=8; rnd held at 14.
  - Required: die_valid and err rise at cycle 9 after roll; die=0; rej_cnt=8. After ack: err=0, busy=0.
- Handshake and reset:
  - Hold die_ack low for 10 cycles → outputs stable, and a roll pulsed during HOLD is ignored.
  - Assert rst mid-DRAW → the next cycle is IDLE with all outputs 0.
  - Free-run against the live LFSR stage for 200 rolls → every die value is 1..6 and err never rises.
- Saturation:
  - Stimulus: 300 rejected samples over repeated aborted rolls.
  - Required: rej_cnt stops at 255; one more reject leaves it at 255.

Source files
------------

// File: rtl/rng_dice.sv
// Rejection-samples a 4-bit random stream into die faces 1..6 and presents each
// result on a valid/ack handshake. It also counts rejected samples, saturating at 255.
module rng_dice #(
   parameter int MAX_TRIES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rnd,
   input  logic       roll,
   output logic [2:0] die,
   output logic       die_valid,
   input  logic       die_ack,
   output logic       err,
   output logic       busy,
   output logic [7:0] rej_cnt,
   output logic [1:0] dbg_state_o
);

   // Handshake: die/err are valid whenever die_valid=1 and stay stable until
   // die_ack is sampled high in HOLD; an ack is ignored while die_valid=0.
   localparam int TW = $clog2(MAX_TRIES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] tries_q, tries_d;
   logic [2:0]    die_q, die_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [7:0]    rej_q, rej_d;
   logic [3:0]    rnd_hi;

   // Samples 6..11 fold onto faces 1..6, so every face owns exactly two codes.
   assign rnd_hi = rnd - 4'd5;

   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      die_d   = die_q;
      valid_d = valid_q;
      err_d   = err_q;
      rej_d   = rej_q;
      case (state_q)
         S_IDLE: begin
            if (roll) begin
               state_d = S_DRAW;
               tries_d = '0;
            end
         end
         S_DRAW: begin
            if (rnd <= 4'd11) begin
               die_d   = (rnd <= 4'd5) ? (rnd[2:0] + 3'd1) : rnd_hi[2:0];
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end else begin
               if (rej_q != 8'hFF) begin
                  rej_d = rej_q + 8'd1;
               end
               if (tries_q == LAST_TRY) begin
                  die_d   = 3'd0;
                  err_d   = 1'b1;
                  valid_d = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  tries_d = tries_q + 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (die_ack) begin
               valid_d = 1'b0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tries_q <= '0;
         die_q   <= 3'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rej_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         tries_q <= tries_d;
         die_q   <= die_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rej_q   <= rej_d;
      end
   end

   assign die         = die_q;
   assign die_valid   = valid_q;
   assign err         = err_q;
   assign rej_cnt     = rej_q;
   assign busy        = (state_q == S_DRAW) || (state_q == S_HOLD);
   assign dbg_state_o = state_q;

endmodule
